sprite_row_drawer: RTL and testbench

Downstream stage of the sprite frontend. Accepts one draw command per sprite hit (`col_base`, `flip`, `frame_id`, `row_off`) and fetches the 16 pixels of that sprite row from the pattern ROM. Writes the non-transparent, on-screen pixels into the scanline buffer that the display side reads on the next line. It reports idle/busy back to the frontend on `draw_done`.

---
 rtl/sprite_row_drawer_if.sv | 26 ++
 rtl/sprite_row_drawer.sv | 128 ++++++++++++
 tb/tb_sprite_row_drawer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_row_drawer_if.sv
// Bus bundle between the sprite frontend, pattern ROM, line buffer and the row drawer.
// Command handshake: draw_req is a one-cycle pulse that is taken only while draw_done=1; it is dropped otherwise.
interface sprite_row_drawer_if;
  logic       row_start;
  logic       draw_req;
  logic [9:0] col_base;
  logic       flip;
  logic [7:0] frame_id;
  logic [3:0] row_off;
  logic       draw_done;
  logic [15:0] rom_addr;
  logic [7:0] rom_data;
  logic       lb_we;
  logic [9:0] lb_addr;
  logic [7:0] lb_data;

  modport slave (
    input  row_start, draw_req, col_base, flip, frame_id, row_off, rom_data,
    output draw_done, rom_addr, lb_we, lb_addr, lb_data
  );

  modport master (
    output row_start, draw_req, col_base, flip, frame_id, row_off, rom_data,
    input  draw_done, rom_addr, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/sprite_row_drawer.sv
// Fetches one 16-pixel sprite row from a synchronous pattern ROM and writes the
// opaque, on-screen pixels into the scanline buffer through a 2-stage pipeline.
module sprite_row_drawer #(
  parameter int         SCREEN_W    = 640,
  parameter logic [7:0] TRANSPARENT = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_row_drawer_if.slave    bus,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);

  state_t      state_q;
  logic [9:0]  col_q;
  logic        flip_q;
  logic [7:0]  frame_q;
  logic [3:0]  row_q;
  logic [3:0]  x_q;
  logic        drain_q;
  logic [15:0] rom_addr_q;
  logic        v1_q;
  logic [10:0] sx1_q;
  logic        done_q;
  logic        lb_we_q;
  logic [9:0]  lb_addr_q;
  logic [7:0]  lb_data_q;

  logic [3:0]  x_d;
  logic [10:0] sx_d;
  logic        lb_we_d;
  logic [15:0] start_addr_d;
  logic [15:0] next_addr_d;

  // rom_addr is registered one step ahead so ROM data lines up with stage 1.
  always_comb begin
    x_d          = x_q + 4'd1;
    sx_d         = {1'b0, col_q} + {7'd0, x_q};
    lb_we_d      = v1_q && (bus.rom_data != TRANSPARENT) && (sx1_q < SCREEN_W_L);
    start_addr_d = {bus.frame_id, bus.row_off, (bus.flip ? 4'hF : 4'h0)};
    next_addr_d  = {frame_q, row_q, (flip_q ? ~x_d : x_d)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      flip_q     <= 1'b0;
      frame_q    <= '0;
      row_q      <= '0;
      x_q        <= '0;
      drain_q    <= 1'b0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      sx1_q      <= '0;
      done_q     <= 1'b1;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
    end else if (bus.row_start) begin
      state_q <= S_IDLE;
      done_q  <= 1'b1;
      v1_q    <= 1'b0;
      lb_we_q <= 1'b0;
    end else begin
      lb_we_q <= lb_we_d;
      if (v1_q) begin
        lb_addr_q <= sx1_q[9:0];
        lb_data_q <= bus.rom_data;
      end
      unique case (state_q)
        S_IDLE: begin
          v1_q <= 1'b0;
          if (bus.draw_req) begin
            col_q      <= bus.col_base;
            flip_q     <= bus.flip;
            frame_q    <= bus.frame_id;
            row_q      <= bus.row_off;
            x_q        <= 4'd0;
            rom_addr_q <= start_addr_d;
            done_q     <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          v1_q  <= 1'b1;
          sx1_q <= sx_d;
          if (x_q == 4'd15) begin
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            x_q        <= x_d;
            rom_addr_q <= next_addr_d;
          end
        end
        S_DRAIN: begin
          v1_q <= 1'b0;
          if (drain_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          v1_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.draw_done = done_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.lb_we     = lb_we_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.lb_data   = lb_data_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sprite_row_drawer.sv
// Directed bench for sprite_row_drawer: per-cycle output log checked against
// hand-derived pixel positions, colours and draw_done timing.
module tb_sprite_row_drawer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state;
  int         cyc = 0;
  int         rom_mode = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       we_at   [4096];
  logic [9:0] addr_at [4096];
  logic [7:0] data_at [4096];
  logic       done_at [4096];

  sprite_row_drawer_if bus ();

  sprite_row_drawer #(.SCREEN_W(640), .TRANSPARENT(8'h00)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: low byte of address, px 0 transparent; mode 1: every pixel opaque
  function automatic logic [7:0] rom_fn(input logic [15:0] a, input int mode);
    if (mode == 0) return (a[3:0] == 4'd0) ? 8'h00 : a[7:0];
    return {4'h8, a[3:0]};
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr, rom_mode);

  always @(negedge clk) begin
    if (cyc < 4096) begin
      we_at[cyc]   = bus.lb_we;
      addr_at[cyc] = bus.lb_addr;
      data_at[cyc] = bus.lb_data;
      done_at[cyc] = bus.draw_done;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; leaves the bench at the next negedge
  task automatic issue(input logic [9:0] col, input logic f, input logic [7:0] fr,
                       input logic [3:0] row, output int n);
    bus.col_base = col;
    bus.flip     = f;
    bus.frame_id = fr;
    bus.row_off  = row;
    bus.draw_req = 1'b1;
    n = cyc;
    step(1);
    bus.draw_req = 1'b0;
  endtask

  task automatic check_draw(input string name, input int n, input logic [9:0] col,
                            input logic f, input logic [7:0] fr, input logic [3:0] row);
    int busy;
    for (int k = 0; k < 16; k++) begin
      int         sx;
      logic [3:0] px;
      logic [7:0] d;
      logic       ew;
      sx = int'(col) + k;
      px = f ? 4'(15 - k) : 4'(k);
      d  = rom_fn({fr, row, px}, rom_mode);
      ew = (d != 8'h00) && (sx < 640);
      check($sformatf("%s_we_k%0d", name, k), 32'(we_at[n+3+k]), 32'(ew));
      if (ew) begin
        check($sformatf("%s_addr_k%0d", name, k), 32'(addr_at[n+3+k]), 32'(sx));
        check($sformatf("%s_data_k%0d", name, k), 32'(data_at[n+3+k]), 32'(d));
      end
    end
    check({name, "_we_pre"}, 32'(we_at[n+2]), 32'd0);
    check({name, "_we_post"}, 32'(we_at[n+19]), 32'd0);
    busy = 0;
    for (int c = n; c <= n + 19; c++) if (done_at[c] == 1'b0) busy++;
    check({name, "_busy_cycles"}, 32'(busy), 32'd18);
    check({name, "_done_n1"}, 32'(done_at[n+1]), 32'd0);
    check({name, "_done_n19"}, 32'(done_at[n+19]), 32'd1);
  endtask

  initial begin
    int n, n2, cnt;
    bus.row_start = 1'b0;
    bus.draw_req  = 1'b0;
    bus.col_base  = '0;
    bus.flip      = 1'b0;
    bus.frame_id  = '0;
    bus.row_off   = '0;

    step(3);
    check("rst_done", 32'(bus.draw_done), 32'd1);
    check("rst_we", 32'(bus.lb_we), 32'd0);
    check("rst_addr", 32'(bus.lb_addr), 32'd0);
    check("rst_data", 32'(bus.lb_data), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    step(2);

    // basic draw
    rom_mode = 0;
    issue(10'd100, 1'b0, 8'd3, 4'd5, n);
    step(22);
    check_draw("basic", n, 10'd100, 1'b0, 8'd3, 4'd5);
    check("basic_px0_skip", 32'(we_at[n+3]), 32'd0);
    check("basic_px1_addr", 32'(addr_at[n+4]), 32'd101);
    check("basic_px1_data", 32'(data_at[n+4]), 32'h51);

    // flip
    issue(10'd100, 1'b1, 8'd3, 4'd5, n);
    step(22);
    check_draw("flip", n, 10'd100, 1'b1, 8'd3, 4'd5);
    check("flip_x100_addr", 32'(addr_at[n+3]), 32'd100);
    check("flip_x100_data", 32'(data_at[n+3]), 32'h5F);
    check("flip_x115_skip", 32'(we_at[n+18]), 32'd0);

    // clipping at right edge
    rom_mode = 1;
    issue(10'd630, 1'b0, 8'd3, 4'd5, n);
    step(22);
    check_draw("clip", n, 10'd630, 1'b0, 8'd3, 4'd5);
    cnt = 0;
    for (int c = n; c <= n + 21; c++) if (we_at[c]) cnt++;
    check("clip_write_count", 32'(cnt), 32'd10);

    // request while busy is dropped; next one at N+19 is taken
    rom_mode = 0;
    issue(10'd300, 1'b0, 8'd1, 4'd2, n);
    step(4);
    bus.col_base = 10'd200;
    bus.draw_req = 1'b1;
    step(1);
    bus.draw_req = 1'b0;
    step(13);
    issue(10'd40, 1'b0, 8'd2, 4'd7, n2);
    check("busy_n2_offset", 32'(n2 - n), 32'd19);
    step(22);
    check_draw("busy_first", n, 10'd300, 1'b0, 8'd1, 4'd2);
    check_draw("busy_third", n2, 10'd40, 1'b0, 8'd2, 4'd7);
    cnt = 0;
    for (int c = n; c <= n2 + 21; c++)
      if (we_at[c] && addr_at[c] >= 10'd200 && addr_at[c] <= 10'd215) cnt++;
    check("busy_no_200", 32'(cnt), 32'd0);

    // abort with row_start, then immediate new request
    issue(10'd500, 1'b0, 8'd4, 4'd9, n);
    step(7);
    bus.row_start = 1'b1;
    step(1);
    bus.row_start = 1'b0;
    issue(10'd60, 1'b1, 8'd5, 4'd3, n2);
    step(22);
    check("abort_n2_offset", 32'(n2 - n), 32'd9);
    check("abort_we_n8", 32'(we_at[n+8]), 32'd1);
    check("abort_addr_n8", 32'(addr_at[n+8]), 32'd505);
    check("abort_done_n9", 32'(done_at[n+9]), 32'd1);
    cnt = 0;
    for (int c = n + 9; c <= n + 11; c++) if (we_at[c]) cnt++;
    check("abort_we_off", 32'(cnt), 32'd0);
    check_draw("abort_next", n2, 10'd60, 1'b1, 8'd5, 4'd3);

    // reset mid-draw
    issue(10'd10, 1'b0, 8'd6, 4'd1, n);
    step(9);
    check("mid_we_before", 32'(bus.lb_we), 32'd1);
    reset = 1'b1;
    step(1);
    check("mid_done", 32'(bus.draw_done), 32'd1);
    check("mid_we", 32'(bus.lb_we), 32'd0);
    check("mid_addr", 32'(bus.lb_addr), 32'd0);
    check("mid_data", 32'(bus.lb_data), 32'd0);
    check("mid_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("mid_state", 32'(state), 32'd0);
    reset = 1'b0;
    step(1);
    issue(10'd20, 1'b0, 8'd7, 4'd8, n);
    step(22);
    check_draw("after_rst", n, 10'd20, 1'b0, 8'd7, 4'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
